// File: rtl/irq_pkg.sv
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared types and constants for the interrupt arbiter front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package irq_pkg;

  localparam int          N_SRC_DEF      = 16;
  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h1000_0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_edge_detect.sv
// ============================================================================
// Module   : irq_edge_detect
// Brief    : Vectored rising-edge detector; IRQ_SYNC_EN adds a 2-flop sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_edge_detect #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] src_i,
  output logic [N-1:0] edge_o
);

  logic [N-1:0] w_s;
  logic [N-1:0] r_s_q;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = src_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_s_q <= '0;
    else         r_s_q <= w_s;
  end

  assign edge_o = w_s & ~r_s_q;

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// Module   : irq_arbiter
// Brief    : Pending/mask registers, fixed-priority pick and take/return FSM.
// Revision : 1.0  (IRQ_SYNC_EN selects the input synchronizer)
// ============================================================================
`default_nettype none

module irq_arbiter
  import irq_pkg::*;
#(
  parameter  int N_SRC = N_SRC_DEF,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] src_i,
  input  logic             mask_we_i,
  input  logic [N_SRC-1:0] mask_wdata_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] mask_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             irq_lost_o
);

  irq_state_e       r_state, w_next;
  logic [ID_W-1:0]  r_id, w_win;
  logic [N_SRC-1:0] r_pending, r_mask;
  logic [N_SRC-1:0] w_edge, w_cand, w_clr;
  logic             w_load, r_lost;

  irq_edge_detect #(.N(N_SRC)) u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .src_i  (src_i),
    .edge_o (w_edge)
  );

  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    w_cand = r_pending & r_mask;
    w_win  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == REQ && irq_taken_i) w_clr[r_id] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_cand) begin
          w_next = REQ;
          w_load = 1'b1;
        end
      end
      REQ:     if (irq_taken_i) w_next = SERVICE;
      SERVICE: if (irq_ret_i)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_next;
      if (w_load) r_id <= w_win;
      // A new edge outranks the take-clear on the same source.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_we_i) r_mask <= mask_wdata_i;
      r_lost    <= |(w_edge & r_pending & ~w_clr);
    end
  end

  assign irq_req_o  = (r_state == REQ);
  assign irq_id_o   = r_id;
  assign mask_o     = r_mask;
  assign pending_o  = r_pending;
  assign irq_lost_o = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// Module   : tb_irq_arbiter
// Brief    : Self-checking bench: vector table, directed corners, random vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_irq_arbiter;
  import irq_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  src_i = '0;
  logic          mask_we_i = 1'b0;
  logic [N-1:0]  mask_wdata_i = '0;
  logic          irq_taken_i = 1'b0;
  logic          irq_ret_i = 1'b0;
  logic          irq_req_o;
  logic [IW-1:0] irq_id_o;
  logic [N-1:0]  mask_o;
  logic [N-1:0]  pending_o;
  logic          irq_lost_o;

  always #5 clk_i = ~clk_i;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .src_i        (src_i),
    .mask_we_i    (mask_we_i),
    .mask_wdata_i (mask_wdata_i),
    .irq_taken_i  (irq_taken_i),
    .irq_ret_i    (irq_ret_i),
    .irq_req_o    (irq_req_o),
    .irq_id_o     (irq_id_o),
    .mask_o       (mask_o),
    .pending_o    (pending_o),
    .irq_lost_o   (irq_lost_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int lost_seen = 0;

  // Reference model: state 0 = idle, 1 = requesting, 2 = in service.
  logic [N-1:0]  m_pend, m_mask, m_prev, m_s1, m_s2;
  int            m_st;
  logic [IW-1:0] m_id;
  logic          m_lost;

  function automatic void model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    m_st = 0; m_id = '0; m_lost = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] src, input logic we,
                                     input logic [N-1:0] wd, input logic tk, input logic rt);
    logic [N-1:0] s, edg, clr, cand, low;
    int idx;
`ifdef IRQ_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = src;
`else
    s = src;
`endif
    edg    = s & ~m_prev;
    m_prev = s;
    clr    = (m_st == 1 && tk) ? (N'(1) << m_id) : '0;
    m_lost = |(edg & m_pend & ~clr);
    cand   = m_pend & m_mask;
    if (m_st == 0 && cand != '0) begin
      low = cand & (~cand + N'(1));
      idx = 0;
      for (int b = 0; b < N; b++) if (low[b]) idx = b;
      m_id = IW'(idx);
      m_st = 1;
    end else if (m_st == 1 && tk) begin
      m_st = 2;
    end else if (m_st == 2 && rt) begin
      m_st = 0;
    end
    m_pend = (m_pend & ~clr) | edg;
    if (we) m_mask = wd;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    n_tests++;
    if (irq_lost_o === 1'b1) lost_seen++;
    if (irq_req_o !== (m_st == 1) || irq_id_o !== m_id || pending_o !== m_pend ||
        mask_o !== m_mask || irq_lost_o !== m_lost) begin
      n_fail++;
      $display("FAIL model t=%0t req=%b/%b id=%0d/%0d pend=%h/%h mask=%h/%h lost=%b/%b",
               $time, irq_req_o, (m_st == 1), irq_id_o, m_id, pending_o, m_pend,
               mask_o, m_mask, irq_lost_o, m_lost);
    end
  endtask

  task automatic step(input logic [N-1:0] src, input logic we, input logic [N-1:0] wd,
                      input logic tk, input logic rt);
    src_i = src; mask_we_i = we; mask_wdata_i = wd; irq_taken_i = tk; irq_ret_i = rt;
    model_step(src, we, wd, tk, rt);
    @(posedge clk_i); #1;
    check_model();
  endtask

  typedef struct {
    logic [N-1:0]  src;
    logic          we;
    logic [N-1:0]  wd;
    logic          tk;
    logic          rt;
    logic          req;
    logic [IW-1:0] id;
    logic [N-1:0]  pend;
    logic [N-1:0]  mask;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] src, input logic we, input logic [N-1:0] wd,
                              input logic tk, input logic rt, input logic req,
                              input logic [IW-1:0] id, input logic [N-1:0] pend,
                              input logic [N-1:0] mask);
    vec_t v;
    v.src = src; v.we = we; v.wd = wd; v.tk = tk; v.rt = rt;
    v.req = req; v.id = id; v.pend = pend; v.mask = mask;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // Single source 5, then simultaneous 3 and 9 with 9 served after return.
    tbl[0]  = mk(16'h0000, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'hFFFF);
    tbl[1]  = mk(16'h0020, 0, 16'h0000, 0, 0, 0, 0, 16'h0020, 16'hFFFF);
    tbl[2]  = mk(16'h0000, 0, 16'h0000, 0, 0, 1, 5, 16'h0020, 16'hFFFF);
    tbl[3]  = mk(16'h0000, 0, 16'h0000, 0, 0, 1, 5, 16'h0020, 16'hFFFF);
    tbl[4]  = mk(16'h0000, 0, 16'h0000, 1, 0, 0, 5, 16'h0000, 16'hFFFF);
    tbl[5]  = mk(16'h0000, 0, 16'h0000, 0, 0, 0, 5, 16'h0000, 16'hFFFF);
    tbl[6]  = mk(16'h0000, 0, 16'h0000, 0, 1, 0, 5, 16'h0000, 16'hFFFF);
    tbl[7]  = mk(16'h0208, 0, 16'h0000, 0, 0, 0, 5, 16'h0208, 16'hFFFF);
    tbl[8]  = mk(16'h0000, 0, 16'h0000, 0, 0, 1, 3, 16'h0208, 16'hFFFF);
    tbl[9]  = mk(16'h0000, 0, 16'h0000, 1, 0, 0, 3, 16'h0200, 16'hFFFF);
    tbl[10] = mk(16'h0000, 0, 16'h0000, 0, 1, 0, 3, 16'h0200, 16'hFFFF);
    tbl[11] = mk(16'h0000, 0, 16'h0000, 0, 0, 1, 9, 16'h0200, 16'hFFFF);
    tbl[12] = mk(16'h0000, 0, 16'h0000, 1, 0, 0, 9, 16'h0000, 16'hFFFF);
    tbl[13] = mk(16'h0000, 0, 16'h0000, 0, 1, 0, 9, 16'h0000, 16'hFFFF);

    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", {irq_req_o, irq_id_o, pending_o, mask_o, irq_lost_o}, '0);
    check_model();
    rst_ni = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].src, tbl[i].we, tbl[i].wd, tbl[i].tk, tbl[i].rt);
      chk($sformatf("vec%0d", i), {irq_req_o, irq_id_o, pending_o, mask_o},
          {tbl[i].req, tbl[i].id, tbl[i].pend, tbl[i].mask});
    end

    // Masked source stays pending; unmasking makes it eligible.
    step(16'h0000, 1, 16'h0000, 0, 0);
    step(16'h0004, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("masked_pending", {irq_req_o, pending_o}, {1'b0, 16'h0004});
    step(16'h0000, 1, 16'h0004, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("unmask_req", {irq_req_o, irq_id_o}, {1'b1, 4'd2});
    step(16'h0000, 0, 16'h0000, 1, 0);
    step(16'h0000, 0, 16'h0000, 0, 1);

    // Second edge on an already-pending source is coalesced and flagged.
    step(16'h0000, 1, 16'hFFFF, 0, 0);
    lost_seen = 0;
    step(16'h0080, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0080, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("lost_once", lost_seen, 1);
    step(16'h0000, 0, 16'h0000, 1, 0);
    step(16'h0000, 0, 16'h0000, 0, 1);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("served_once", {irq_req_o, pending_o}, {1'b0, 16'h0000});

    // Latched request is not re-arbitrated by a higher-priority arrival.
    step(16'h0010, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0001, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("no_preempt", {irq_req_o, irq_id_o}, {1'b1, 4'd4});
    step(16'h0000, 0, 16'h0000, 1, 0);
    chk("pend_after_take", pending_o, 16'h0001);
    step(16'h0000, 0, 16'h0000, 0, 1);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("src0_after_ret", {irq_req_o, irq_id_o}, {1'b1, 4'd0});
    step(16'h0000, 0, 16'h0000, 1, 0);

    // Asynchronous reset while in service with another event pending.
    step(16'h0100, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset", {irq_req_o, irq_id_o, pending_o, mask_o, irq_lost_o}, '0);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(16'h0000, 1, 16'hFFFF, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("no_req_after_reset", {irq_req_o, pending_o}, {1'b0, 16'h0000});
    step(16'h0040, 0, 16'h0000, 0, 0);
    step(16'h0000, 0, 16'h0000, 0, 0);
    chk("req_after_new_edge", {irq_req_o, irq_id_o}, {1'b1, 4'd6});
    step(16'h0000, 0, 16'h0000, 1, 0);
    step(16'h0000, 0, 16'h0000, 0, 1);

    // Random traffic against the model.
    begin
      logic [N-1:0] rs, rwd;
      logic rwe, rtk, rrt;
      rs = '0;
      for (int c = 0; c < 3000; c++) begin
        rs  = rs ^ (N'($urandom) & N'($urandom) & N'($urandom));
        rwe = ($urandom_range(0, 19) == 0);
        rwd = N'($urandom);
        rtk = (m_st == 1 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
        rrt = (m_st == 2 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 15) == 0);
        step(rs, rwe, rwd, rtk, rrt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
# irq_arbiter

Upstream front end of the core's interrupt path: collects `N_SRC` peripheral interrupt lines, latches rising edges as pending events, applies a software mask and picks one source by fixed priority. It drives the single `irq_req` input of the interrupt controller. It tracks the controller's take and return (`irq_o` / `irq_ret_o`), so exactly one source is in service at a time and its identity is stable for the handler.

## Interface
- `N_SRC`, 16 — number of interrupt sources, 2..32
- `ID_W`, `$clog2(N_SRC)` — width of source index (derived, not overridden)

- `clk_i` in 1 — clock
- `rst_ni` in 1 — reset, asynchronous, active-low
- `src_i` in N_SRC — raw peripheral interrupt lines, active-high
- `mask_we_i` in 1 — write strobe for the mask register
- `mask_wdata_i` in N_SRC — new mask value; 1 = enabled
- `irq_taken_i` in 1 — controller `irq_o`; one-cycle pulse, interrupt accepted
- `irq_ret_i` in 1 — controller `irq_ret_o`; `mret` retired
- `irq_req_o` out 1 — request to controller `irq_req_i`
- `irq_id_o` out ID_W — index of requested/in-service source
- `mask_o` out N_SRC — current mask readback
- `pending_o` out N_SRC — pending vector readback
- `irq_lost_o` out 1 — one-cycle pulse: an edge arrived on an already-pending source

## Operation
- Edge detect per source: `edge[i] = s[i] & ~s_q[i]`.
  - `s` is `src_i`, or the synchronized copy when `IRQ_SYNC_EN` is defined.
  - `s_q` is `s` delayed one cycle.
- `pending[i]` is set on `edge[i]` and cleared when source `i` is taken. If set and clear hit the same cycle, set wins.
- An edge on a source whose `pending[i]` is already 1 and is not being cleared that cycle pulses `irq_lost_o`. The events are coalesced.
- Candidates: `pending & mask`. Lowest index has highest priority.
- Masked sources stay pending and are never dropped. Unmasking later makes them eligible.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when any candidate exists. The winner index is latched into `id_q`.
  - REQ → SERVICE on `irq_taken_i`. `pending[id_q]` is cleared on the same edge.
  - SERVICE → IDLE on `irq_ret_i`.
  - `irq_ret_i` seen in IDLE or REQ is ignored.
- In REQ, the latched request is never retracted or re-arbitrated, even if a higher-priority source arrives or the mask changes.
- `irq_req_o = (state == REQ)`. `irq_id_o = id_q` in all states.
- Mask write takes effect on the edge where `mask_we_i` is high. Arbitration in the following cycle uses the new value.

## Timing
- Reset values:
  - `irq_req_o` = 0, `irq_id_o` = 0, `irq_lost_o` = 0
  - `pending_o` = 0, `mask_o` = 0 (all masked)
  - state = IDLE, all edge/sync flops = 0
- Latency without sync: `src_i` is sampled high at edge k (with `s_q` = 0) → `pending` set after edge k → `irq_req_o` high after edge k+1.
- `IRQ_SYNC_EN` adds 2 cycles.
- `irq_req_o` holds until the edge that samples `irq_taken_i`, and falls in the next cycle.
- Minimum time from `irq_ret_i` to the next `irq_req_o`: 2 edges (SERVICE→IDLE, IDLE→REQ).
- A source held high continuously produces one event only. It must go low, then high again, to re-trigger.
- Reset asserted mid-service returns to IDLE immediately and discards all pending events.

## Configuration
- `IRQ_SYNC_EN`
  - Defined: each `src_i` bit passes through a 2-flop synchronizer before edge detect. Use for asynchronous peripheral domains.
  - Undefined: `src_i` feeds edge detect directly and is assumed synchronous to `clk_i`.

## Structure
- Package `irq_pkg` holds:
  - the `irq_state_e` enum (IDLE, REQ, SERVICE)
  - the `N_SRC_DEF` = 16 default
  - the `IRQ_CAUSE_BASE` = 32'h1000_0010 constant shared with the controller
- Sub-module `irq_edge_detect`, one instance per source or vectored:
  - contains the optional synchronizer, the `s_q` flop and the edge output
  - all `IRQ_SYNC_EN` ifdefs are confined here
- The arbiter module owns the pending/mask registers, priority encoder and FSM.

## Test plan
- Reset, mask = 0xFFFF, pulse `src_i[5]` for 1 cycle → `irq_req_o` high 2 cycles later, `irq_id_o` = 5. Pulse `irq_taken_i` → `pending_o` = 0, state SERVICE. Pulse `irq_ret_i` → IDLE.
- Edges on sources 3 and 9 in the same cycle → id 3 served first. After `irq_ret_i`, id 9 is requested with no new edge.
- Mask = 0x0000, edge on source 2 → `pending_o` = 0x0004 and no request. Write mask = 0x0004 → `irq_req_o` within 2 cycles, id 2.
- Two edges on source 7 while pending → `irq_lost_o` pulses once, and source 7 is serviced once.
- In REQ with id 4, edge on source 0 → `irq_id_o` stays 4 until taken. Source 0 is requested after return.
- Assert `rst_ni` low asynchronously in SERVICE → all outputs 0 immediately. After release, no request until a new edge.
